iq_frame_sync_ctrl: RTL
=======================

Name: iq_frame_sync_ctrl

Overview:
- Lock/sequencing controller downstream of the IQ analyse datapath.
- Consumes the per-bit differential outputs (DI/DQ), the bit index and the max-amplitude sync pulse.
- Finds which bit slot in the 80-slot frame carries the strongest differential energy, and tracks that slot's stability frame to frame.
- Drives a SEARCH/CONFIRM/LOCKED state machine; downstream demod uses `locked` and `frame_phase` to align symbol decisions.

Parameters:
- DATA_WIDTH, 16, width of DI_out/DQ_out samples (signed).
- FRAME_LEN, 80, bit slots per frame; bits_count runs 0..FRAME_LEN-1.
- LOCK_COUNT, 4, consecutive matching frames needed to declare lock (2..15).
- MISS_LIMIT, 3, consecutive non-matching frames that drop lock (1..15).
- PHASE_TOL, 1, max circular distance, in slots, between successive peak indices that still counts as a match.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ce, input, 1, clock enable; sample events are ignored when low.
- max_val_sync, input, 1, one-cycle sample-event pulse from the datapath.
- bits_count, input, 7, bit slot index, valid with max_val_sync.
- DI_out, input, DATA_WIDTH signed, in-phase differential.
- DQ_out, input, DATA_WIDTH signed, quadrature differential.
- threshold, input, DATA_WIDTH+1, minimum peak magnitude for a valid frame; quasi-static.
- locked, output, 1, high in LOCKED state.
- sync_state, output, 2, 0=SEARCH, 1=CONFIRM, 2=LOCKED.
- frame_phase, output, 7, reference peak slot index.
- peak_mag, output, DATA_WIDTH+1, peak magnitude of the last evaluated frame.
- frame_done, output, 1, one-cycle pulse per evaluated frame.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): all outputs 0, state SEARCH, internal running peak/index/conf/miss counters 0. Reset mid-frame discards the partial frame.
- Sample event: ce=1 and max_val_sync=1. Events are guaranteed at least 4 cycles apart; no overlap handling is required.
- Stage 1 (event cycle +1): register mag = |DI_out| + |DQ_out|.
  - Computed at DATA_WIDTH+1 bits; |-32768| = 32768, no saturation. Max value 65536 fits 17 bits.
  - Register bits_count alongside, plus last = (bits_count == FRAME_LEN-1).
- Stage 2 (+2): if mag > run_peak (strict, so the first occurrence wins ties), load run_peak=mag and run_idx=index.
- Stage 3 (+3, only if last):
  - Evaluate the frame, update the FSM, load peak_mag=run_peak, pulse frame_done.
  - Clear run_peak and run_idx to 0 in the same cycle, so the next frame starts fresh.
  - The stage-2 update from the last sample is included in the evaluation.
- Frame with no events ending at slot 79: not evaluated. The first evaluation after reset uses whatever slots arrived before the first slot-79 event.
- Evaluation terms:
  - valid = run_peak >= threshold.
  - dist = min(|run_idx-ref|, FRAME_LEN-|run_idx-ref|).
  - match = valid && dist <= PHASE_TOL.
- FSM transitions, taken only at stage 3:
  - SEARCH: valid → ref=run_idx, conf=1, go CONFIRM. Else stay.
  - CONFIRM:
    - match → ref=run_idx, conf=conf+1; if conf+1 == LOCK_COUNT go LOCKED with miss=0.
    - valid but not match → ref=run_idx, conf=1, stay.
    - not valid → conf=0, go SEARCH.
  - LOCKED:
    - match → ref=run_idx, miss=0.
    - else miss=miss+1 and ref held; if miss+1 == MISS_LIMIT go SEARCH with conf=0, miss=0.
- Output timing:
  - frame_phase = ref, updated in the stage-3 cycle.
  - locked = (state == LOCKED), registered, so it changes on the cycle after the transition edge, together with sync_state.
- ce low on an event cycle suppresses only that event; pipeline stages already in flight complete.
- Out-of-range bits_count (≥ FRAME_LEN) is treated as a normal index. It can never set last and is excluded from wrap-distance math by clamping dist to FRAME_LEN-1.

Decomposition:
- Shared package iq_sync_pkg:
  - state encoding (SEARCH/CONFIRM/LOCKED);
  - FRAME_LEN default;
  - function circ_dist(a, b, len) returning the circular distance.
- One natural sub-module: iq_mag_peak, covering the abs-sum, running peak and index over stages 1–2 with a clear-on-evaluate input. The FSM and counters stay in the top.

Test Plan:
- Reset check: assert rst for 3 cycles mid-stream → all outputs 0 and sync_state=0; the partial frame is not evaluated.
- Acquire lock: threshold=1000; 4 frames each with DI=2000, DQ=-500 at slot 17, zeros elsewhere.
  - sync_state goes 1 after frame 1 and 2 after frame 4.
  - frame_phase=17, peak_mag=2500.
  - frame_done pulses exactly 3 cycles after each slot-79 event.
- Tolerance: locked at 17; next frames peak at 18, then 20.
  - Slot 18 matches: ref=18, miss=0.
  - Slot 20 misses: miss=1, ref held at 18.
  - Wrap case: ref=79, peak at 0 → match (dist 1).
- Lose lock: locked, then 3 frames with all magnitudes below threshold=1000 → sync_state 2,2,2→0 on the third evaluation; locked falls; conf=0.
- Magnitude edge and tie: DI=-32768, DQ=-32768 at slot 5 and again at slot 9 → peak_mag=65536, frame_phase=5 (first occurrence kept).
- ce gating: the event carrying the frame maximum arrives with ce=0 → it is ignored, the next-highest slot is chosen, and frame_done timing is unchanged.

Source files
------------

// File: rtl/iq_sync_pkg.sv
// Shared definitions for the IQ frame-sync controller: lock states,
// the default frame length and the wrap-around slot distance helper.
package iq_sync_pkg;

  localparam int FRAME_LEN_DEF = 80;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_t;

  // Circular distance between two slot indices in a frame of 'len' slots.
  // An index outside the frame has no meaningful wrap position, so the
  // distance is pinned to the largest in-frame value and can never match.
  function automatic logic [6:0] circ_dist(input logic [6:0] a,
                                           input logic [6:0] b,
                                           input logic [6:0] len);
    logic [6:0] d;
    logic [6:0] w;
    d = (a >= b) ? (a - b) : (b - a);
    w = len - d;
    if ((a >= len) || (b >= len))
      circ_dist = len - 7'd1;
    else if (d < w)
      circ_dist = d;
    else
      circ_dist = w;
  endfunction

endpackage

// File: rtl/iq_mag_peak.sv
// Magnitude and running-peak tracker: |DI|+|DQ| per sample event, then the
// strongest slot seen so far in the current frame. A clear input restarts
// the search once the frame has been evaluated.
module iq_mag_peak
  import iq_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_event,
  input  logic [6:0]            i_bits_count,
  input  logic [DATA_WIDTH-1:0] i_di_out,
  input  logic [DATA_WIDTH-1:0] i_dq_out,
  input  logic                  i_clear,
  output logic [DATA_WIDTH:0]   o_run_peak,
  output logic [6:0]            o_run_idx,
  output logic                  o_last
);

  localparam logic [6:0]          LAST_SLOT = 7'(FRAME_LEN - 1);
  localparam logic [DATA_WIDTH:0] ONE       = (DATA_WIDTH + 1)'(1);

  logic [DATA_WIDTH:0] w_di_ext;
  logic [DATA_WIDTH:0] w_dq_ext;
  logic [DATA_WIDTH:0] w_abs_di;
  logic [DATA_WIDTH:0] w_abs_dq;
  logic [DATA_WIDTH:0] w_mag;

  logic                r_v1;
  logic                r_last1;
  logic [6:0]          r_idx1;
  logic [DATA_WIDTH:0] r_mag;
  logic [DATA_WIDTH:0] r_run_peak;
  logic [6:0]          r_run_idx;
  logic                r_last2;

  // One extra bit lets |-2^(N-1)| and the sum of two such values fit exactly.
  always_comb begin
    w_di_ext = {i_di_out[DATA_WIDTH-1], i_di_out};
    w_dq_ext = {i_dq_out[DATA_WIDTH-1], i_dq_out};
    w_abs_di = w_di_ext[DATA_WIDTH] ? ((~w_di_ext) + ONE) : w_di_ext;
    w_abs_dq = w_dq_ext[DATA_WIDTH] ? ((~w_dq_ext) + ONE) : w_dq_ext;
    w_mag    = w_abs_di + w_abs_dq;
  end

  // Stage 1: capture magnitude, slot index and end-of-frame flag per event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_idx1  <= '0;
      r_mag   <= '0;
    end else begin
      r_v1 <= i_event;
      if (i_event) begin
        r_mag   <= w_mag;
        r_idx1  <= i_bits_count;
        r_last1 <= (i_bits_count == LAST_SLOT);
      end
    end
  end

  // Stage 2: strict compare keeps the earliest slot when magnitudes tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run_peak <= '0;
      r_run_idx  <= '0;
      r_last2    <= 1'b0;
    end else begin
      r_last2 <= r_v1 & r_last1;
      if (i_clear) begin
        r_run_peak <= '0;
        r_run_idx  <= '0;
      end else if (r_v1 && (r_mag > r_run_peak)) begin
        r_run_peak <= r_mag;
        r_run_idx  <= r_idx1;
      end
    end
  end

  assign o_run_peak = r_run_peak;
  assign o_run_idx  = r_run_idx;
  assign o_last     = r_last2;

endmodule

// File: rtl/iq_frame_sync_ctrl.sv
// Frame-sync lock controller: evaluates each completed frame's peak slot
// and walks SEARCH -> CONFIRM -> LOCKED, dropping lock after repeated misses.
module iq_frame_sync_ctrl
  import iq_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3,
  parameter int PHASE_TOL  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic                  i_max_val_sync,
  input  logic [6:0]            i_bits_count,
  input  logic [DATA_WIDTH-1:0] i_di_out,
  input  logic [DATA_WIDTH-1:0] i_dq_out,
  input  logic [DATA_WIDTH:0]   i_threshold,
  output logic                  o_locked,
  output logic [1:0]            o_sync_state,
  output logic [6:0]            o_frame_phase,
  output logic [DATA_WIDTH:0]   o_peak_mag,
  output logic                  o_frame_done
);

  localparam logic [6:0] FRAME_LEN_W = 7'(FRAME_LEN);
  localparam logic [6:0] TOL_W       = 7'(PHASE_TOL);
  localparam logic [3:0] LOCK_CNT    = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_LIM    = 4'(MISS_LIMIT);

  logic                w_event;
  logic [DATA_WIDTH:0] w_run_peak;
  logic [6:0]          w_run_idx;
  logic                w_eval;
  logic                w_valid;
  logic [6:0]          w_dist;
  logic                w_match;

  sync_state_t         r_state;
  sync_state_t         w_state_nxt;
  logic [3:0]          r_conf;
  logic [3:0]          w_conf_nxt;
  logic [3:0]          r_miss;
  logic [3:0]          w_miss_nxt;
  logic [6:0]          r_ref;
  logic [6:0]          w_ref_nxt;

  logic                r_locked;
  logic [1:0]          r_sync_state;
  logic [DATA_WIDTH:0] r_peak_mag;
  logic                r_frame_done;

  assign w_event = i_ce & i_max_val_sync;

  iq_mag_peak #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_mag_peak (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_event      (w_event),
    .i_bits_count (i_bits_count),
    .i_di_out     (i_di_out),
    .i_dq_out     (i_dq_out),
    .i_clear      (w_eval),
    .o_run_peak   (w_run_peak),
    .o_run_idx    (w_run_idx),
    .o_last       (w_eval)
  );

  // Per-frame verdict and lock state progression, active only on evaluation.
  always_comb begin
    w_state_nxt = r_state;
    w_conf_nxt  = r_conf;
    w_miss_nxt  = r_miss;
    w_ref_nxt   = r_ref;
    w_valid     = (w_run_peak >= i_threshold);
    w_dist      = circ_dist(w_run_idx, r_ref, FRAME_LEN_W);
    w_match     = w_valid && (w_dist <= TOL_W);
    if (w_eval) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_valid) begin
            w_ref_nxt   = w_run_idx;
            w_conf_nxt  = 4'd1;
            w_state_nxt = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (w_match) begin
            w_ref_nxt  = w_run_idx;
            w_conf_nxt = r_conf + 4'd1;
            if ((r_conf + 4'd1) == LOCK_CNT) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = 4'd0;
            end
          end else if (w_valid) begin
            w_ref_nxt  = w_run_idx;
            w_conf_nxt = 4'd1;
          end else begin
            w_conf_nxt  = 4'd0;
            w_state_nxt = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_ref_nxt  = w_run_idx;
            w_miss_nxt = 4'd0;
          end else if ((r_miss + 4'd1) == MISS_LIM) begin
            w_state_nxt = ST_SEARCH;
            w_conf_nxt  = 4'd0;
            w_miss_nxt  = 4'd0;
          end else begin
            w_miss_nxt = r_miss + 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_conf_nxt  = 4'd0;
          w_miss_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Lock state, confidence/miss counters and reference phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_SEARCH;
      r_conf  <= 4'd0;
      r_miss  <= 4'd0;
      r_ref   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_conf  <= w_conf_nxt;
      r_miss  <= w_miss_nxt;
      r_ref   <= w_ref_nxt;
    end
  end

  // Registered status: lock flags trail the state change by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_locked     <= 1'b0;
      r_sync_state <= 2'd0;
      r_peak_mag   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_locked     <= (r_state == ST_LOCKED);
      r_sync_state <= r_state;
      r_frame_done <= w_eval;
      if (w_eval)
        r_peak_mag <= w_run_peak;
    end
  end

  assign o_locked      = r_locked;
  assign o_sync_state  = r_sync_state;
  assign o_frame_phase = r_ref;
  assign o_peak_mag    = r_peak_mag;
  assign o_frame_done  = r_frame_done;

endmodule
